// File: rtl/x4xx_qsfp_pkt_pkg.sv
// x4xx_qsfp_pkt_pkg: checker states, header layout and payload pattern shared by the QSFP traffic generator and checker
package x4xx_qsfp_pkt_pkg;

    localparam int SEQ_LSB = 0;
    localparam int LEN_LSB = 16;
    localparam int MAX_W   = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DRAIN,
        ST_DONE
    } pkt_state_t;

    // Every 32-bit lane of payload word idx carries {seq, idx}; lanes above width are zero
    function automatic logic [MAX_W-1:0] pkt_pattern(input logic [15:0] seq, input logic [15:0] idx, input int width);
        pkt_pattern = '0;
        for (int i = 0; i < MAX_W / 32; i++)
            if (i < width / 32) pkt_pattern[i*32 +: 32] = {seq, idx};
    endfunction

endpackage

// File: rtl/x4xx_qsfp_pkt_checker.sv
// x4xx_qsfp_pkt_checker: per-lane receive checker for generated QSFP packets (seq, length, tlast and payload pattern)
module x4xx_qsfp_pkt_checker
    import x4xx_qsfp_pkt_pkg::*;
#(
    parameter int CHDR_W   = 64,
    parameter int NUM_PKTS = 16,
    parameter int MAX_LEN  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHDR_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              done,
    output logic              pass,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count,
    output logic              err_seq,
    output logic              err_len,
    output logic              err_data
);

    localparam logic [15:0] L_NUM = 16'(NUM_PKTS);
    localparam logic [15:0] L_MAX = 16'(MAX_LEN);

    pkt_state_t  r_state, w_next;
    logic [15:0] r_seq, r_len, r_idx, r_exp_seq, r_pkt_count, r_err_count;
    logic        r_p_seq, r_p_len, r_p_data, r_nocount;
    logic        r_err_seq, r_err_len, r_err_data, r_done, r_pass;
    logic        w_hs, w_seq_bad, w_len_bad, w_data_bad, w_last_idx, w_mid;
    logic        w_end, w_cnt, w_bad, w_e_seq, w_e_len, w_e_data;
    logic [15:0] w_hdr_seq, w_hdr_len, w_pkt_nxt, w_err_nxt;

    assign s_axis_tready = r_state != ST_IDLE;
    assign w_hs          = s_axis_tvalid && s_axis_tready;
    assign w_hdr_seq     = s_axis_tdata[SEQ_LSB +: 16];
    assign w_hdr_len     = s_axis_tdata[LEN_LSB +: 16];
    assign w_seq_bad     = w_hdr_seq != r_exp_seq;
    assign w_len_bad     = w_hdr_len < 16'd2 || w_hdr_len > L_MAX;
    assign w_data_bad    = MAX_W'(s_axis_tdata) != pkt_pattern(r_seq, r_idx, CHDR_W);
    assign w_last_idx    = r_idx == r_len - 16'd1;
    // A start that lands inside a packet must drain its remainder without counting it
    assign w_mid         = (r_state == ST_PAYLOAD || r_state == ST_DRAIN || (r_state == ST_HDR && w_hs))
                           && !(w_hs && s_axis_tlast);
    assign w_cnt         = w_end && !start;
    assign w_bad         = w_e_seq || w_e_len || w_e_data;
    assign w_pkt_nxt     = r_pkt_count + 16'd1;
    assign w_err_nxt     = (w_bad && r_err_count != 16'hFFFF) ? r_err_count + 16'd1 : r_err_count;

    always_comb begin
        w_next   = r_state;
        w_end    = 1'b0;
        w_e_seq  = r_p_seq;
        w_e_len  = r_p_len;
        w_e_data = r_p_data;
        case (r_state)
            ST_HDR: if (w_hs) begin
                w_e_seq  = w_seq_bad;
                w_e_len  = 1'b1;
                w_e_data = 1'b0;
                w_end    = s_axis_tlast;
                w_next   = s_axis_tlast ? ST_HDR : (w_len_bad ? ST_DRAIN : ST_PAYLOAD);
            end
            ST_PAYLOAD: if (w_hs) begin
                w_e_data = r_p_data || w_data_bad;
                w_e_len  = r_p_len || !w_last_idx;
                w_end    = s_axis_tlast;
                w_next   = s_axis_tlast ? ST_HDR : (w_last_idx ? ST_DRAIN : ST_PAYLOAD);
            end
            ST_DRAIN: if (w_hs && s_axis_tlast) begin
                w_end  = !r_nocount;
                w_next = ST_HDR;
            end
            default: ;
        endcase
        if (w_end && w_pkt_nxt == L_NUM) w_next = ST_DONE;
        if (start) w_next = w_mid ? ST_DRAIN : ST_HDR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_seq       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_exp_seq   <= '0;
            r_pkt_count <= '0;
            r_err_count <= '0;
            r_p_seq     <= 1'b0;
            r_p_len     <= 1'b0;
            r_p_data    <= 1'b0;
            r_nocount   <= 1'b0;
            r_err_seq   <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_data  <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hs && r_state == ST_HDR) begin
                r_seq     <= w_hdr_seq;
                r_len     <= w_hdr_len;
                r_idx     <= 16'd1;
                r_exp_seq <= w_hdr_seq + 16'd1;
                r_p_seq   <= w_seq_bad;
                r_p_len   <= w_len_bad;
                r_p_data  <= 1'b0;
            end
            if (w_hs && r_state == ST_PAYLOAD) begin
                r_idx    <= r_idx + 16'd1;
                r_p_data <= w_e_data;
                r_p_len  <= r_p_len || (w_last_idx && !s_axis_tlast);
            end
            if (w_hs && s_axis_tlast) r_nocount <= 1'b0;
            if (w_cnt) begin
                r_pkt_count <= w_pkt_nxt;
                r_err_count <= w_err_nxt;
                r_err_seq   <= r_err_seq || w_e_seq;
                r_err_len   <= r_err_len || w_e_len;
                r_err_data  <= r_err_data || w_e_data;
                r_done      <= w_pkt_nxt == L_NUM;
                r_pass      <= w_pkt_nxt == L_NUM && w_err_nxt == 16'd0;
            end
            if (start) begin
                r_exp_seq   <= '0;
                r_pkt_count <= '0;
                r_err_count <= '0;
                r_err_seq   <= 1'b0;
                r_err_len   <= 1'b0;
                r_err_data  <= 1'b0;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
                r_nocount   <= w_mid;
            end
        end
    end

    assign done      = r_done;
    assign pass      = r_pass;
    assign pkt_count = r_pkt_count;
    assign err_count = r_err_count;
    assign err_seq   = r_err_seq;
    assign err_len   = r_err_len;
    assign err_data  = r_err_data;

endmodule

// File: tb/tb_x4xx_qsfp_pkt_checker.sv
// tb_x4xx_qsfp_pkt_checker: table-driven packet bench with a per-packet status scoreboard, 64- and 512-bit instances
module tb_x4xx_qsfp_pkt_checker;

    logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, tvalid = 1'b0, tlast = 1'b0;
    logic [63:0]  td64 = '0;
    logic [511:0] td512 = '0;
    logic         rdy_a, dn_a, ps_a, es_a, el_a, ed_a;
    logic         rdy_b, dn_b, ps_b, es_b, el_b, ed_b;
    logic [15:0]  pc_a, ec_a, pc_b, ec_b;

    always #5 clk = ~clk;

    x4xx_qsfp_pkt_checker #(.CHDR_W(64), .NUM_PKTS(16), .MAX_LEN(256)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .s_axis_tdata(td64), .s_axis_tlast(tlast),
        .s_axis_tvalid(tvalid), .s_axis_tready(rdy_a), .done(dn_a), .pass(ps_a), .pkt_count(pc_a),
        .err_count(ec_a), .err_seq(es_a), .err_len(el_a), .err_data(ed_a));

    x4xx_qsfp_pkt_checker #(.CHDR_W(512), .NUM_PKTS(16), .MAX_LEN(256)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .s_axis_tdata(td512), .s_axis_tlast(tlast),
        .s_axis_tvalid(tvalid), .s_axis_tready(rdy_b), .done(dn_b), .pass(ps_b), .pkt_count(pc_b),
        .err_count(ec_b), .err_seq(es_b), .err_len(el_b), .err_data(ed_b));

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ec;
        logic es, el, ed, dn, ps;
    } exp_t;

    typedef struct {
        int seq;
        int len;
        int nw;
        int flip;
        bit es, el, ed;
    } pkt_t;

    exp_t        sb[$];
    pkt_t        tbl[69];
    int          n_chk = 0, n_fail = 0, stalls = 0, m_pc = 0, m_ec = 0;
    bit          gap_en = 1'b0, m_es = 1'b0, m_el = 1'b0, m_ed = 1'b0;
    logic [15:0] prev_pc = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int seq, input int idx);
        for (int l = 0; l < 16; l++) pat[l*32 +: 32] = {seq[15:0], idx[15:0]};
    endfunction

    // One record per counted packet; popped when the DUT's pkt_count moves
    always @(negedge clk) begin
        if (pc_a != prev_pc) begin
            exp_t e;
            prev_pc = pc_a;
            if (pc_a != 16'd0) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: pkt_count=%0d with no packet expected", pc_a);
                end else begin
                    e = sb.pop_front();
                    chk("sb_w64", {pc_a, ec_a, es_a, el_a, ed_a, dn_a, ps_a}, e);
                    chk("sb_w512", {pc_b, ec_b, es_b, el_b, ed_b, dn_b, ps_b}, e);
                end
            end
        end
    end

    task automatic push(input pkt_t p);
        exp_t e;
        m_pc++;
        m_ec += (p.es || p.el || p.ed) ? 1 : 0;
        m_es |= p.es;
        m_el |= p.el;
        m_ed |= p.ed;
        e.pc = 16'(m_pc);
        e.ec = 16'(m_ec);
        e.es = m_es;
        e.el = m_el;
        e.ed = m_ed;
        e.dn = m_pc == 16;
        e.ps = m_pc == 16 && m_ec == 0;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [511:0] w, input bit last);
        int n = 0;
        if (gap_en) repeat ($urandom_range(0, 2)) begin
            tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        td64   = w[63:0];
        td512  = w;
        tlast  = last;
        tvalid = 1'b1;
        while (!rdy_a && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            stalls++;
        end
        if (!rdy_a) begin
            n_fail++;
            $display("FAIL tready_timeout: tready=%b after %0d cycles, required 1", rdy_a, n);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $fatal(1, "tready timeout");
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_pkt(input pkt_t p, input bit counted);
        logic [511:0] w;
        for (int i = 0; i < p.nw; i++) begin
            w = (i == 0) ? {448'h0, 32'hdeadbeef, p.len[15:0], p.seq[15:0]} : pat(p.seq, i);
            if (p.flip != 0 && i == p.flip) w[0] = ~w[0];
            if (counted && i == p.nw - 1) push(p);
            send_word(w, i == p.nw - 1);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_pc  = 0;
        m_ec  = 0;
        m_es  = 1'b0;
        m_el  = 1'b0;
        m_ed  = 1'b0;
    endtask

    task automatic settle(input string nm);
        repeat (3) @(posedge clk);
        #1;
        chk(nm, sb.size(), 0);
    endtask

    task automatic run(input int lo, input int hi);
        do_start();
        for (int i = lo; i <= hi; i++) send_pkt(tbl[i], 1'b1);
        settle("sb_empty");
    endtask

    initial begin
        pkt_t r;
        for (int i = 0; i < 16; i++) begin
            tbl[i]      = '{i, 4, 4, 0, 1'b0, 1'b0, 1'b0};
            tbl[16 + i] = '{(i < 3) ? i : i + 1, 4, 4, 0, i == 3, 1'b0, 1'b0};
            tbl[32 + i] = '{i, 4, 4, 0, 1'b0, 1'b0, 1'b0};
            tbl[48 + i] = '{i, 4, 4, 0, 1'b0, 1'b0, 1'b0};
        end
        tbl[37] = '{5, 8, 6, 0, 1'b0, 1'b1, 1'b0};
        tbl[38] = '{6, 4, 7, 0, 1'b0, 1'b1, 1'b0};
        tbl[55] = '{7, 4, 4, 2, 1'b0, 1'b0, 1'b1};
        tbl[64] = '{0, 1, 3, 0, 1'b0, 1'b1, 1'b0};
        tbl[65] = '{1, 300, 5, 0, 1'b0, 1'b1, 1'b0};
        tbl[66] = '{2, 4, 1, 0, 1'b0, 1'b1, 1'b0};
        tbl[67] = '{3, 4, 4, 0, 1'b0, 1'b0, 1'b0};
        tbl[68] = '{9, 4, 4, 1, 1'b1, 1'b0, 1'b1};

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_w64", {rdy_a, pc_a, ec_a, dn_a, ps_a, es_a, el_a, ed_a}, 0);
        chk("reset_w512", {rdy_b, pc_b, ec_b, dn_b, ps_b, es_b, el_b, ed_b}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        stalls = 0;
        run(0, 15);
        chk("bubble_stalls", stalls, 0);
        chk("clean_done_pass", {dn_a, ps_a, dn_b, ps_b}, 4'hF);
        send_pkt(tbl[1], 1'b0);
        settle("done_discard_sb");
        chk("done_discard_count", pc_a, 16);

        run(16, 31);
        chk("seq_skip_flags", {es_a, el_a, ed_a, dn_a, ps_a}, 5'b10010);
        run(32, 47);
        chk("len_err_count", {el_a, ec_a, el_b, ec_b}, {1'b1, 16'd2, 1'b1, 16'd2});
        run(48, 63);
        chk("data_err_flags", {ed_a, ec_a, ed_b, ec_b}, {1'b1, 16'd1, 1'b1, 16'd1});

        gap_en = 1'b1;
        do_start();
        for (int i = 0; i < 16; i++) begin
            r = '{i, $urandom_range(2, 256), 0, 0, 1'b0, 1'b0, 1'b0};
            r.nw = r.len;
            send_pkt(r, 1'b1);
        end
        gap_en = 1'b0;
        settle("rand_sb_empty");
        chk("rand_pass", {dn_a, ps_a, dn_b, ps_b}, 4'hF);

        run(64, 68);
        chk("len_bounds", {es_a, el_a, ed_a, ec_a}, {3'b111, 16'd4});

        do_start();
        for (int i = 0; i < 9; i++) send_pkt(tbl[i], 1'b1);
        settle("pre_start_sb");
        chk("pre_start_count", pc_a, 9);
        send_word({448'h0, 32'h0, 16'd4, 16'd9}, 1'b0);
        send_word(pat(9, 1), 1'b0);
        do_start();
        chk("start_clear", {pc_a, ec_a, dn_a, ps_a, es_a, el_a, ed_a}, 0);
        chk("start_tready", rdy_a, 1);
        send_word(pat(9, 2), 1'b0);
        send_word(pat(9, 3), 1'b1);
        for (int i = 0; i < 16; i++) send_pkt(tbl[i], 1'b1);
        settle("restart_sb_empty");
        chk("restart_pass", {dn_a, ps_a, dn_b, ps_b}, 4'hF);

        do_start();
        send_pkt(tbl[0], 1'b1);
        send_pkt(tbl[1], 1'b1);
        settle("arst_pre_sb");
        send_word({448'h0, 32'h0, 16'd4, 16'd2}, 1'b0);
        send_word(pat(2, 1), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_w64", {rdy_a, pc_a, ec_a, dn_a, ps_a, es_a, el_a, ed_a}, 0);
        chk("arst_w512", {rdy_b, pc_b, ec_b, dn_b, ps_b, es_b, el_b, ed_b}, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        td64   = {32'h0, 16'd4, 16'd0};
        td512  = {480'h0, 16'd4, 16'd0};
        tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_tready", {rdy_a, rdy_b, pc_a}, 0);
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        do_start();
        send_pkt(tbl[0], 1'b1);
        settle("post_arst_sb");
        chk("post_arst_count", {pc_a, pc_b}, {16'd1, 16'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
